// File: rtl/crc5_pkg.sv
// Shared CRC-5 definitions: polynomial, frame FSM states, 4-bit parallel CRC step.
// Latency: combinational helper function only, no state.
// Backpressure: n/a.
//
// Contents: CRC5_POLY (x^5+x^2+1 without the implicit x^5 term), crc_state_t,
// crc5_nib_step(c, d) folding one nibble (bit 3 first) into a CRC value.
package crc5_pkg;

    localparam logic [4:0] CRC5_POLY = 5'b00101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } crc_state_t;

    // Four serial LFSR steps unrolled into one combinational update.
    // No reflection and no final XOR; MSB of the nibble goes in first.
    function automatic logic [4:0] crc5_nib_step(input logic [4:0] c, input logic [3:0] d);
        logic [4:0] r;
        logic       fb;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            fb = r[4] ^ d[i];
            r  = {r[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
        end
        return r;
    endfunction

endpackage

// File: rtl/crc5_frame_ctrl_if.sv
// Frame-control bus between the packet framer and the CRC frame sequencer.
// Latency: wires only.
// Backpressure: in_valid/in_ready stream for nibbles; start is a pulse sampled in IDLE.
//
// master = framer side (drives start/frame/data), slave = crc5_frame_ctrl.
interface crc5_frame_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             check_en;
    logic [4:0]       crc_exp;
    logic             abort;
    logic [3:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             busy;
    logic [4:0]       crc_out;
    logic             crc_valid;
    logic             crc_err;
    logic             timeout;

    modport master (
        output start, frame_len, check_en, crc_exp, abort, in_data, in_valid,
        input  in_ready, busy, crc_out, crc_valid, crc_err, timeout
    );

    modport slave (
        input  start, frame_len, check_en, crc_exp, abort, in_data, in_valid,
        output in_ready, busy, crc_out, crc_valid, crc_err, timeout
    );
endinterface

// File: rtl/crc5_nib_engine.sv
// CRC-5 register folding one nibble per enabled cycle.
// Latency: 1 cycle from en/load to updated crc.
// Backpressure: none; caller gates en with its own handshake.
//
// Ports: clk, rst (async high), load (reseed to CRC_INIT, wins over en),
// en (fold d into crc), d[3:0] nibble, crc[4:0] current register value.
module crc5_nib_engine
    import crc5_pkg::*;
#(
    parameter logic [4:0] CRC_INIT = 5'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] d,
    output logic [4:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC_INIT;
        end else if (load) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc5_nib_step(crc, d);
        end
    end

endmodule

// File: rtl/crc5_frame_ctrl.sv
// Frame sequencer: takes start+length, accepts that many nibbles, reports CRC-5 result.
// Latency: crc_valid rises 1 cycle after the edge that samples the last beat (or the start for len=0).
// Backpressure: in_ready is high only while BUSY; a stall of TMO_CYC cycles drops the frame.
//
// Ports: clk, rst (async high), bus (slave modport of crc5_frame_ctrl_if).
// All outputs are registered. abort beats both a same-cycle beat and a timeout.
module crc5_frame_ctrl
    import crc5_pkg::*;
#(
    parameter int         LEN_W    = 8,
    parameter logic [4:0] CRC_INIT = 5'h00,
    parameter int         TMO_CYC  = 16
) (
    input  logic               clk,
    input  logic               rst,
    crc5_frame_ctrl_if.slave   bus
);

    localparam int STALL_W = $clog2(TMO_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TMO_CYC - 1);

    crc_state_t         state;
    logic [LEN_W-1:0]   cnt;
    logic [STALL_W-1:0] stall;
    logic               chk_q;
    logic [4:0]         exp_q;
    logic [4:0]         crc_reg;

    logic beat;
    logic eng_load;
    logic eng_en;

    // in_ready is itself registered to track BUSY, so it qualifies the beat.
    assign beat     = bus.in_valid && bus.in_ready;
    assign eng_load = (state == IDLE) && bus.start;
    assign eng_en   = (state == BUSY) && beat && !bus.abort;

    crc5_nib_engine #(
        .CRC_INIT (CRC_INIT)
    ) u_engine (
        .clk  (clk),
        .rst  (rst),
        .load (eng_load),
        .en   (eng_en),
        .d    (bus.in_data),
        .crc  (crc_reg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            stall         <= '0;
            chk_q         <= 1'b0;
            exp_q         <= 5'h00;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.crc_out   <= 5'h00;
            bus.crc_valid <= 1'b0;
            bus.crc_err   <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.crc_valid <= 1'b0;
            bus.crc_err   <= 1'b0;
            bus.timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt      <= bus.frame_len;
                        chk_q    <= bus.check_en;
                        exp_q    <= bus.crc_exp;
                        stall    <= '0;
                        bus.busy <= 1'b1;
                        if (bus.frame_len == '0) begin
                            state <= DONE;
                        end else begin
                            state        <= BUSY;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.abort) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.in_ready <= 1'b0;
                    end else if (beat) begin
                        cnt   <= cnt - LEN_W'(1);
                        stall <= '0;
                        if (cnt == LEN_W'(1)) begin
                            state        <= DONE;
                            bus.in_ready <= 1'b0;
                        end
                    end else if (stall == STALL_LAST) begin
                        // This idle cycle is the TMO_CYC-th in a row.
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.in_ready <= 1'b0;
                        bus.timeout  <= 1'b1;
                    end else if (stall != '1) begin
                        stall <= stall + STALL_W'(1);
                    end
                end
                DONE: begin
                    // Result is published from here so an abort in DONE leaves crc_out untouched.
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    if (!bus.abort) begin
                        bus.crc_valid <= 1'b1;
                        bus.crc_out   <= crc_reg;
                        bus.crc_err   <= chk_q && (crc_reg != exp_q);
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
